pc_redirect_unit: RTL

- Fetch-side consumer of the pipeline's branch/jump decision ("leap").
- Owns the architectural PC and drives the instruction-memory fetch address.
- Loads the IF/ID pipeline register.
- On a taken leap, redirects the PC to the resolved target and squashes the wrongly fetched sequential instruction by converting it to a NOP bubble.
- Sits between instruction memory and the ID stage, where leap and the target are produced.

---
 rtl/pc_redirect_unit.sv | 91 +++++++++
 1 files changed

// File: rtl/pc_redirect_unit.sv
// rtl/pc_redirect_unit.sv - fetch PC owner, IF/ID register load, taken-leap redirect and squash
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h5400_0000,
    parameter int          CNT_W     = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             leap,
    input  logic [31:0]      target,
    input  logic [31:0]      imem_data,
    output logic [31:0]      imem_addr,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc4,
    output logic             if_id_valid,
    output logic             squashing,
    output logic             align_err,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_SQUASH = 1'b1;

    logic [31:0]      pc_q;
    logic [31:0]      pc_plus4;
    logic [31:0]      instr_q;
    logic [31:0]      pc4_q;
    logic             valid_q;
    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             align_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;
    logic             cnt_full;

    // A leap is only trusted when ID holds a real instruction and its operands are current.
    assign accept   = leap & ~stall & valid_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign cnt_full = &cnt_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    state_d = accept ? ST_SQUASH : ST_RUN;
            ST_SQUASH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            state_q <= ST_RUN;
            align_q <= 1'b0;
            cnt_q   <= '0;
        end else if (stall) begin
            align_q <= 1'b0;
        end else if (accept) begin
            // The word fetched this cycle is on the wrong path; replace it with a bubble.
            pc_q    <= {target[31:2], 2'b00};
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'd0;
            valid_q <= 1'b0;
            state_q <= state_d;
            align_q <= |target[1:0];
            if (!cnt_full) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            pc_q    <= pc_plus4;
            instr_q <= imem_data;
            pc4_q   <= pc_plus4;
            valid_q <= 1'b1;
            state_q <= state_d;
            align_q <= 1'b0;
        end
    end

    assign imem_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign squashing    = (state_q == ST_SQUASH);
    assign align_err    = align_q;
    assign redirect_cnt = cnt_q;

endmodule
